// File: rtl/ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the MIPS execute stage and its iterative
// multiply/divide unit:
//   - ALUOp encodings driven by the main decoder
//   - R-type funct field constants
//   - internal ALU operation enum and its decoder
//   - multiply/divide FSM state encoding
//   - default iteration count and the one-bit-per-cycle datapath step
// No ports; imported by ex_muldiv and ex_stage.
// ---------------------------------------------------------------------------
package ex_stage_pkg;

   localparam int MD_CYCLES_DEFAULT = 32;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_MFHI,
      ALU_MFLO,
      ALU_MULT,
      ALU_DIV,
      ALU_NONE
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Translate the decoder's ALUOp plus the funct field into one internal
   // operation; unknown funct codes map to ALU_NONE, which yields zero.
   function automatic alu_op_e decode_alu_op(input logic [1:0] aluop,
                                             input logic [5:0] funct);
      alu_op_e op;
      op = ALU_NONE;
      case (aluop)
         ALUOP_ADD, ALUOP_ADDI: op = ALU_ADD;
         ALUOP_SUB:             op = ALU_SUB;
         default: begin
            case (funct)
               FUNCT_ADD:  op = ALU_ADD;
               FUNCT_SUB:  op = ALU_SUB;
               FUNCT_AND:  op = ALU_AND;
               FUNCT_OR:   op = ALU_OR;
               FUNCT_SLT:  op = ALU_SLT;
               FUNCT_MFHI: op = ALU_MFHI;
               FUNCT_MFLO: op = ALU_MFLO;
               FUNCT_MULT: op = ALU_MULT;
               FUNCT_DIV:  op = ALU_DIV;
               default:    op = ALU_NONE;
            endcase
         end
      endcase
      return op;
   endfunction

   // One iteration of the unsigned magnitude datapath, shared by both
   // operations on the same {w_hi, w_lo} register pair.
   // Multiply: w_lo holds the multiplier, w_hi the partial product; each
   // step conditionally adds the multiplicand and shifts right by one.
   // Divide: w_lo holds the dividend shifting out / quotient shifting in,
   // w_hi the partial remainder; each step is one restoring subtraction.
   function automatic logic [63:0] md_step(input logic        is_div,
                                           input logic [31:0] mag,
                                           input logic [31:0] w_hi,
                                           input logic [31:0] w_lo);
      logic [32:0] sum;
      logic [32:0] shifted;
      logic [32:0] trial;
      logic [63:0] res;
      sum     = {1'b0, w_hi} + (w_lo[0] ? {1'b0, mag} : 33'd0);
      shifted = {w_hi, w_lo[31]};
      trial   = shifted - {1'b0, mag};
      if (!is_div) begin
         res = {sum, w_lo[31:1]};
      end else if (!trial[32]) begin
         res = {trial[31:0], w_lo[30:0], 1'b1};
      end else begin
         res = {shifted[31:0], w_lo[30:0], 1'b0};
      end
      return res;
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// Iterative signed multiply / divide unit owning the HI and LO registers.
// One magnitude bit is retired per clock; the result is sign-corrected and
// committed to HI/LO on the edge that takes the FSM from BUSY to DONE.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active low
//   start  in   a MULT or DIV is sitting in EX
//   op     in   0 = MULT, 1 = DIV
//   a, b   in   32-bit signed operands (dividend / divisor for DIV)
//   busy   out  combinational stall request for the hazard unit
//   hi     out  committed HI register
//   lo     out  committed LO register
// ---------------------------------------------------------------------------
module ex_muldiv
   import ex_stage_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(MD_CYCLES - 2);

   md_state_e   state;
   md_state_e   state_next;
   logic [CW-1:0] cnt;
   logic        last_step;

   logic        is_div;
   logic        neg_res;
   logic        a_neg;
   logic        b_zero;
   logic [31:0] mag_m;
   logic [31:0] w_hi;
   logic [31:0] w_lo;

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] load_m;
   logic [31:0] load_lo;
   logic [63:0] load_step;
   logic [63:0] run_step;
   logic [63:0] prod_signed;
   logic [31:0] quo_signed;
   logic [31:0] rem_signed;
   logic [31:0] hi_final;
   logic [31:0] lo_final;

   // The counter reaching MD_CYCLES-1 happens on the edge leaving
   // the cycle where it still reads MD_CYCLES-2.
   assign last_step = (cnt == LAST_STEP);

   // Operand magnitudes and the first iteration are formed straight from
   // the inputs so the load edge already retires one bit; together with
   // the MD_CYCLES-1 BUSY edges that gives exactly MD_CYCLES iterations.
   assign a_mag     = a[31] ? (~a + 32'd1) : a;
   assign b_mag     = b[31] ? (~b + 32'd1) : b;
   assign load_m    = op ? b_mag : a_mag;
   assign load_lo   = op ? a_mag : b_mag;
   assign load_step = md_step(op, load_m, 32'd0, load_lo);
   assign run_step  = md_step(is_div, mag_m, w_hi, w_lo);

   // State register: reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MD_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DONE always falls back to IDLE so the MULT/DIV
   // still held in EX during its release cycle does not start again.
   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE: if (start)     state_next = MD_BUSY;
         MD_BUSY: if (last_step) state_next = MD_DONE;
         MD_DONE:                state_next = MD_IDLE;
         default:                state_next = MD_IDLE;
      endcase
   end

   // Output logic: the stall rises in the very cycle the operation enters
   // EX and is held low while reset is asserted, even if a MULT/DIV is
   // still presented at the inputs.
   always_comb begin
      busy = rst && (((state == MD_IDLE) && start) || (state == MD_BUSY));
   end

   // Sign correction of the finished magnitude result. For a zero divisor
   // the remainder magnitude ends up equal to the dividend magnitude, so
   // the sign-corrected remainder is already the dividend; only LO needs
   // the explicit all-ones override.
   always_comb begin
      prod_signed = neg_res ? (~run_step + 64'd1) : run_step;
      quo_signed  = neg_res ? (~run_step[31:0] + 32'd1) : run_step[31:0];
      rem_signed  = a_neg ? (~run_step[63:32] + 32'd1) : run_step[63:32];
      hi_final    = rem_signed;
      lo_final    = quo_signed;
      if (!is_div) begin
         hi_final = prod_signed[63:32];
         lo_final = prod_signed[31:0];
      end else if (b_zero) begin
         lo_final = 32'hFFFF_FFFF;
      end
   end

   // Iterative datapath and HI/LO. Operands and signs are captured on the
   // start edge; HI/LO only change on the final BUSY edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         a_neg   <= 1'b0;
         b_zero  <= 1'b0;
         mag_m   <= '0;
         w_hi    <= '0;
         w_lo    <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (state == MD_IDLE) begin
         if (start) begin
            cnt     <= '0;
            is_div  <= op;
            neg_res <= a[31] ^ b[31];
            a_neg   <= a[31];
            b_zero  <= (b == 32'd0);
            mag_m   <= load_m;
            w_hi    <= load_step[63:32];
            w_lo    <= load_step[31:0];
         end
      end else if (state == MD_BUSY) begin
         cnt  <= cnt + CW'(1);
         w_hi <= run_step[63:32];
         w_lo <= run_step[31:0];
         if (last_step) begin
            hi <= hi_final;
            lo <= lo_final;
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
// Execute stage of the five-stage MIPS pipeline. Selects operand B and the
// destination register, computes the ALU result and branch target, and
// latches everything into the EX/MEM register.
// Optional feature: define EX_MULDIV_EN to build in the iterative
// multiply/divide unit (HI/LO, MULT, DIV, MFHI, MFLO and the stall output).
// Without it those functs give zero and stall is tied low.
// Ports:
//   clk, rst                   clock and asynchronous active-low reset
//   wb_ctlin, m_ctlin          WB / MEM controls from ID/EX (m bit 2 = Branch)
//   ex_ctlin                   {RegDst, ALUOp[1:0], ALUSrc}
//   npcin                      PC+4
//   rdata1in, rdata2in         register operands A and B
//   s_extendin                 sign-extended immediate, [5:0] = funct
//   instrin_2016, instrin_1511 rt and rd
//   wb_ctlout, m_ctlout        registered controls (bubbled during stall)
//   add_result                 registered branch target
//   zero                       registered ALU-result-is-zero flag
//   alu_result                 registered ALU result
//   rdata2out                  registered store data
//   muxout                     registered destination register
//   stall                      combinational freeze for PC, IF/ID, ID/EX
// ---------------------------------------------------------------------------
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wb_ctlin,
   input  logic [2:0]  m_ctlin,
   input  logic [3:0]  ex_ctlin,
   input  logic [31:0] npcin,
   input  logic [31:0] rdata1in,
   input  logic [31:0] rdata2in,
   input  logic [31:0] s_extendin,
   input  logic [4:0]  instrin_2016,
   input  logic [4:0]  instrin_1511,
   output logic [1:0]  wb_ctlout,
   output logic [2:0]  m_ctlout,
   output logic [31:0] add_result,
   output logic        zero,
   output logic [31:0] alu_result,
   output logic [31:0] rdata2out,
   output logic [4:0]  muxout,
   output logic        stall
);

   logic        reg_dst;
   logic [1:0]  alu_op_sel;
   logic        alu_src;
   logic [31:0] operand_b;
   logic [4:0]  dest_reg;
   logic [31:0] branch_target;
   alu_op_e     alu_op;
   logic [31:0] alu_res;
   logic [31:0] hi_val;
   logic [31:0] lo_val;

   // The multiply/divide datapath retires one bit per cycle, so the
   // iteration count has to match the 32-bit operand width.
   if (MD_CYCLES != 32) begin : g_bad_md_cycles
      $error("ex_stage: MD_CYCLES must be 32 for the bit-serial datapath");
   end

   assign {reg_dst, alu_op_sel, alu_src} = ex_ctlin;
   assign operand_b     = alu_src ? s_extendin : rdata2in;
   assign dest_reg      = reg_dst ? instrin_1511 : instrin_2016;
   assign branch_target = npcin + {s_extendin[29:0], 2'b00};
   assign alu_op        = decode_alu_op(alu_op_sel, s_extendin[5:0]);

`ifdef EX_MULDIV_EN
   logic md_start;
   logic md_is_div;

   assign md_start  = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
   assign md_is_div = (alu_op == ALU_DIV);

   ex_muldiv #(
      .MD_CYCLES(MD_CYCLES)
   ) u_muldiv (
      .clk  (clk),
      .rst  (rst),
      .start(md_start),
      .op   (md_is_div),
      .a    (rdata1in),
      .b    (operand_b),
      .busy (stall),
      .hi   (hi_val),
      .lo   (lo_val)
   );
`else
   assign stall  = 1'b0;
   assign hi_val = 32'd0;
   assign lo_val = 32'd0;
`endif

   // ALU: 32-bit wrap-around arithmetic, no overflow trap. MULT/DIV write
   // only HI/LO, so their own ALU result is zero like any unknown funct.
   always_comb begin
      alu_res = 32'd0;
      case (alu_op)
         ALU_ADD:  alu_res = rdata1in + operand_b;
         ALU_SUB:  alu_res = rdata1in - operand_b;
         ALU_AND:  alu_res = rdata1in & operand_b;
         ALU_OR:   alu_res = rdata1in | operand_b;
         ALU_SLT:  alu_res = {31'd0, $signed(rdata1in) < $signed(operand_b)};
         ALU_MFHI: alu_res = hi_val;
         ALU_MFLO: alu_res = lo_val;
         default:  alu_res = 32'd0;
      endcase
   end

   // EX/MEM register. While stalled the controls become a bubble so the
   // held instruction has no side effects downstream; data still flows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_ctlout  <= '0;
         m_ctlout   <= '0;
         add_result <= '0;
         zero       <= 1'b0;
         alu_result <= '0;
         rdata2out  <= '0;
         muxout     <= '0;
      end else begin
         wb_ctlout  <= stall ? 2'b00 : wb_ctlin;
         m_ctlout   <= stall ? 3'b000 : m_ctlin;
         add_result <= branch_target;
         zero       <= (alu_res == 32'd0);
         alu_result <= alu_res;
         rdata2out  <= rdata2in;
         muxout     <= dest_reg;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage. Expected values come from a behavioural
// model written with plain integer arithmetic; mul/div expectations are
// checked only when EX_MULDIV_EN is defined, otherwise the disabled
// behaviour is checked instead.
// ---------------------------------------------------------------------------
module tb_ex_stage;

   localparam int MDC = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wb_ctlin;
   logic [2:0]  m_ctlin;
   logic [3:0]  ex_ctlin;
   logic [31:0] npcin;
   logic [31:0] rdata1in;
   logic [31:0] rdata2in;
   logic [31:0] s_extendin;
   logic [4:0]  instrin_2016;
   logic [4:0]  instrin_1511;
   logic [1:0]  wb_ctlout;
   logic [2:0]  m_ctlout;
   logic [31:0] add_result;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2out;
   logic [4:0]  muxout;
   logic        stall;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   ex_stage #(.MD_CYCLES(MDC)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_ctlin    (wb_ctlin),
      .m_ctlin     (m_ctlin),
      .ex_ctlin    (ex_ctlin),
      .npcin       (npcin),
      .rdata1in    (rdata1in),
      .rdata2in    (rdata2in),
      .s_extendin  (s_extendin),
      .instrin_2016(instrin_2016),
      .instrin_1511(instrin_1511),
      .wb_ctlout   (wb_ctlout),
      .m_ctlout    (m_ctlout),
      .add_result  (add_result),
      .zero        (zero),
      .alu_result  (alu_result),
      .rdata2out   (rdata2out),
      .muxout      (muxout),
      .stall       (stall)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Absolute time limit so a broken design can never hang the run.
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one ID/EX instruction onto the stage inputs.
   task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m,
                                input logic regdst, input logic [1:0] aluop,
                                input logic alusrc, input logic [31:0] npc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sext, input logic [4:0] rt,
                                input logic [4:0] rd);
      wb_ctlin     = wb;
      m_ctlin      = m;
      ex_ctlin     = {regdst, aluop, alusrc};
      npcin        = npc;
      rdata1in     = a;
      rdata2in     = b;
      s_extendin   = sext;
      instrin_2016 = rt;
      instrin_1511 = rd;
   endtask

   // Architectural ALU result for a non-mul/div instruction.
   function automatic logic [31:0] model_alu(input logic [1:0] aluop,
                                             input logic [5:0] funct,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      r = 32'd0;
      if (aluop == 2'b00 || aluop == 2'b11) r = a + b;
      else if (aluop == 2'b01) r = a - b;
      else begin
         case (funct)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`ifdef EX_MULDIV_EN
            6'h10: r = model_hi;
            6'h12: r = model_lo;
`endif
            default: r = 32'd0;
         endcase
      end
      return r;
   endfunction

   // Architectural HI/LO after MULT or DIV, using 64-bit signed arithmetic.
   task automatic model_muldiv(input logic is_div, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] hi,
                               output logic [31:0] lo);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         p  = sa * sb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         hi = r[31:0];
         lo = q[31:0];
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(2'b11, 3'b111, 1'b1, 2'b00, 1'b0, 32'h40, 32'd1, 32'd2,
                    32'd4, 5'd1, 5'd2);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (wb_ctlout !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_wb: got %h expected 0", wb_ctlout); end
      n_checks++; if (m_ctlout !== 3'b000) begin n_fails++; $display("[TB] FAIL reset_m: got %h expected 0", m_ctlout); end
      n_checks++; if (add_result !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_add: got %h expected 0", add_result); end
      n_checks++; if (alu_result !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_alu: got %h expected 0", alu_result); end
      n_checks++; if (rdata2out !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_rdata2: got %h expected 0", rdata2out); end
      n_checks++; if (muxout !== 5'd0) begin n_fails++; $display("[TB] FAIL reset_mux: got %h expected 0", muxout); end
      n_checks++; if (zero !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_zero: got %b expected 0", zero); end
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_sub_zero();
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h200, 32'd5, 32'd5,
                    32'h22, 5'd4, 5'd9);
      @(posedge clk); #1;
      n_checks++; if (alu_result !== 32'd0) begin n_fails++; $display("[TB] FAIL sub_alu: got %h expected 0", alu_result); end
      n_checks++; if (zero !== 1'b1) begin n_fails++; $display("[TB] FAIL sub_zero: got %b expected 1", zero); end
      n_checks++; if (muxout !== 5'd9) begin n_fails++; $display("[TB] FAIL sub_mux: got %0d expected 9", muxout); end
      n_checks++; if (wb_ctlout !== 2'b10) begin n_fails++; $display("[TB] FAIL sub_wb: got %h expected 2", wb_ctlout); end
   endtask

   task automatic test_branch();
      @(negedge clk);
      applyStimulus(2'b00, 3'b100, 1'b0, 2'b01, 1'b0, 32'h100, 32'd7, 32'd7,
                    32'hFFFF_FFFF, 5'd6, 5'd0);
      @(posedge clk); #1;
      n_checks++; if (add_result !== 32'hFC) begin n_fails++; $display("[TB] FAIL branch_target: got %h expected fc", add_result); end
      n_checks++; if (zero !== 1'b1) begin n_fails++; $display("[TB] FAIL branch_zero: got %b expected 1", zero); end
      n_checks++; if (m_ctlout !== 3'b100) begin n_fails++; $display("[TB] FAIL branch_m: got %h expected 4", m_ctlout); end
      n_checks++; if (muxout !== 5'd6) begin n_fails++; $display("[TB] FAIL branch_mux: got %0d expected 6", muxout); end
   endtask

   task automatic test_slt();
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF,
                    32'd1, 32'h2A, 5'd1, 5'd3);
      @(posedge clk); #1;
      n_checks++; if (alu_result !== 32'd1) begin n_fails++; $display("[TB] FAIL slt_neg: got %h expected 1", alu_result); end
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd1,
                    32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd3);
      @(posedge clk); #1;
      n_checks++; if (alu_result !== 32'd0) begin n_fails++; $display("[TB] FAIL slt_pos: got %h expected 0", alu_result); end
      n_checks++; if (zero !== 1'b1) begin n_fails++; $display("[TB] FAIL slt_zero: got %b expected 1", zero); end
   endtask

   task automatic test_random_alu();
      logic [1:0]  aluop, wb;
      logic [2:0]  m;
      logic        regdst, alusrc;
      logic [5:0]  funct;
      logic [31:0] a, b, npc, tmp, sext, bop, exp_alu;
      logic [4:0]  rt, rd;
      for (int i = 0; i < 40; i++) begin
         aluop  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: funct = 6'h20;
            1: funct = 6'h22;
            2: funct = 6'h24;
            3: funct = 6'h25;
            4: funct = 6'h2A;
            5: funct = 6'h10;
            6: funct = 6'h12;
            default: begin
               funct = 6'($urandom_range(0, 63));
               if (funct == 6'h18 || funct == 6'h1A) funct = 6'h3F;
            end
         endcase
         a      = $urandom;
         b      = ($urandom_range(0, 3) == 0) ? a : $urandom;
         tmp    = $urandom;
         sext   = {tmp[31:6], funct};
         npc    = $urandom;
         wb     = 2'($urandom_range(0, 3));
         m      = 3'($urandom_range(0, 7));
         regdst = 1'($urandom_range(0, 1));
         alusrc = ($urandom_range(0, 3) == 0);
         rt     = 5'($urandom_range(0, 31));
         rd     = 5'($urandom_range(0, 31));
         bop     = alusrc ? sext : b;
         exp_alu = model_alu(aluop, funct, a, bop);
         @(negedge clk);
         applyStimulus(wb, m, regdst, aluop, alusrc, npc, a, b, sext, rt, rd);
         @(posedge clk); #1;
         n_checks++; if (alu_result !== exp_alu) begin n_fails++; $display("[TB] FAIL rand_alu[%0d]: got %h expected %h", i, alu_result, exp_alu); end
         n_checks++; if (zero !== (exp_alu == 32'd0)) begin n_fails++; $display("[TB] FAIL rand_zero[%0d]: got %b expected %b", i, zero, exp_alu == 32'd0); end
         n_checks++; if (muxout !== (regdst ? rd : rt)) begin n_fails++; $display("[TB] FAIL rand_mux[%0d]: got %0d expected %0d", i, muxout, regdst ? rd : rt); end
         n_checks++; if (add_result !== npc + sext * 4) begin n_fails++; $display("[TB] FAIL rand_target[%0d]: got %h expected %h", i, add_result, npc + sext * 4); end
         n_checks++; if (rdata2out !== b) begin n_fails++; $display("[TB] FAIL rand_rdata2[%0d]: got %h expected %h", i, rdata2out, b); end
         n_checks++; if ({wb_ctlout, m_ctlout} !== {wb, m}) begin n_fails++; $display("[TB] FAIL rand_ctl[%0d]: got %h expected %h", i, {wb_ctlout, m_ctlout}, {wb, m}); end
      end
   endtask

`ifdef EX_MULDIV_EN
   // Issue MULT/DIV, measure the stall, check the bubble and release, then
   // read back HI and LO with mfhi / mflo.
   task automatic run_muldiv(input logic is_div, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
      int stall_cycles;
      int bubble_bad;
      stall_cycles = 0;
      bubble_bad   = 0;
      @(negedge clk);
      applyStimulus(2'b11, 3'b011, 1'b1, 2'b10, 1'b0, 32'h1000, a, b,
                    {26'd0, is_div ? 6'h1A : 6'h18}, 5'd3, 5'd0);
      for (int i = 0; i < MDC + 5; i++) begin
         #1;
         if (stall !== 1'b1) break;
         stall_cycles++;
         @(posedge clk); #1;
         if (wb_ctlout !== 2'b00 || m_ctlout !== 3'b000) bubble_bad++;
         @(negedge clk);
      end
      n_checks++; if (stall_cycles != MDC) begin n_fails++; $display("[TB] FAIL md_stall_len: got %0d expected %0d", stall_cycles, MDC); end
      n_checks++; if (bubble_bad != 0) begin n_fails++; $display("[TB] FAIL md_bubble: got %0d non-bubble cycles expected 0", bubble_bad); end
      @(posedge clk); #1;
      n_checks++; if ({wb_ctlout, m_ctlout} !== 5'b11011) begin n_fails++; $display("[TB] FAIL md_release_ctl: got %h expected 1b", {wb_ctlout, m_ctlout}); end
      model_hi = exp_hi;
      model_lo = exp_lo;
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd0, 32'd0,
                    32'h10, 5'd0, 5'd8);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("[TB] FAIL md_mfhi_stall: got %b expected 0", stall); end
      @(posedge clk); #1;
      n_checks++; if (alu_result !== exp_hi) begin n_fails++; $display("[TB] FAIL md_hi: got %h expected %h", alu_result, exp_hi); end
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd0, 32'd0,
                    32'h12, 5'd0, 5'd8);
      @(posedge clk); #1;
      n_checks++; if (alu_result !== exp_lo) begin n_fails++; $display("[TB] FAIL md_lo: got %h expected %h", alu_result, exp_lo); end
   endtask

   task automatic test_multiply();
      logic [31:0] a, b, h, l;
      run_muldiv(1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      for (int i = 0; i < 3; i++) begin
         a = $urandom;
         b = $urandom;
         model_muldiv(1'b0, a, b, h, l);
         run_muldiv(1'b0, a, b, h, l);
      end
   endtask

   task automatic test_divide();
      logic [31:0] a, b, h, l;
      run_muldiv(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_muldiv(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_muldiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      for (int i = 0; i < 3; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 28);
         model_muldiv(1'b1, a, b, h, l);
         run_muldiv(1'b1, a, b, h, l);
      end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      applyStimulus(2'b11, 3'b000, 1'b0, 2'b10, 1'b0, 32'h0, 32'd100, 32'd7,
                    32'h1A, 5'd2, 5'd0);
      repeat (11) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("[TB] FAIL busy_reset_stall: got %b expected 0", stall); end
      @(negedge clk);
      applyStimulus(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h0, 32'd0, 32'd0,
                    32'd0, 5'd0, 5'd0);
      rst = 1'b1;
      model_hi = 32'd0;
      model_lo = 32'd0;
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd0, 32'd0,
                    32'h10, 5'd0, 5'd8);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("[TB] FAIL busy_reset_idle: got %b expected 0", stall); end
      @(posedge clk); #1;
      n_checks++; if (alu_result !== model_hi) begin n_fails++; $display("[TB] FAIL busy_reset_hi: got %h expected %h", alu_result, model_hi); end
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd0, 32'd0,
                    32'h12, 5'd0, 5'd8);
      @(posedge clk); #1;
      n_checks++; if (alu_result !== model_lo) begin n_fails++; $display("[TB] FAIL busy_reset_lo: got %h expected %h", alu_result, model_lo); end
   endtask
`else
   task automatic test_muldiv_disabled();
      @(negedge clk);
      applyStimulus(2'b11, 3'b011, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFE,
                    32'd3, 32'h18, 5'd3, 5'd4);
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fails++; $display("[TB] FAIL nomd_stall: got %b expected 0", stall); end
      @(posedge clk); #1;
      n_checks++; if (alu_result !== 32'd0) begin n_fails++; $display("[TB] FAIL nomd_mult: got %h expected 0", alu_result); end
      n_checks++; if ({wb_ctlout, m_ctlout} !== 5'b11011) begin n_fails++; $display("[TB] FAIL nomd_ctl: got %h expected 1b", {wb_ctlout, m_ctlout}); end
      @(negedge clk);
      applyStimulus(2'b10, 3'b000, 1'b1, 2'b10, 1'b0, 32'h0, 32'd9, 32'd9,
                    32'h10, 5'd0, 5'd8);
      @(posedge clk); #1;
      n_checks++; if (alu_result !== 32'd0) begin n_fails++; $display("[TB] FAIL nomd_mfhi: got %h expected 0", alu_result); end
   endtask
`endif

   // Main sequence: hold reset briefly, then run each scenario in turn.
   initial begin
      rst = 1'b0;
      applyStimulus(2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0,
                    32'd0, 5'd0, 5'd0);
      repeat (2) @(negedge clk);
      $display("[TB] starting ex_stage checks");
      test_reset();
      test_sub_zero();
      test_branch();
      test_slt();
      test_random_alu();
`ifdef EX_MULDIV_EN
      test_multiply();
      test_divide();
      test_reset_busy();
`else
      test_muldiv_disabled();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
